// File: rtl/mem_bus_responder.sv
// Wait-state memory responder for the multicycle core's shared memory port.
// One request in flight; word RAM with byte-lane strobes.
module mem_bus_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_check
        $error("mem_bus_responder: LATENCY must be within 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          go;
    logic          in_wait;
    logic          a_write;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [3:0]    a_wstrb;
    logic          a_err;
    logic [AW-1:0] a_idx;
    logic          mem_we;

    assign req_ready = (state != S_WAIT);
    assign accept    = req_valid && req_ready;
    assign in_wait   = (state == S_WAIT);

    // The access happens on the edge entering RESP: either straight from the
    // bus (zero wait states) or from the latched request at the end of WAIT.
    assign go = (accept && (LATENCY == 0)) || (in_wait && (cnt == 4'd0));

    assign a_write = in_wait ? lat_write : req_write;
    assign a_addr  = in_wait ? lat_addr  : req_addr;
    assign a_wdata = in_wait ? lat_wdata : req_wdata;
    assign a_wstrb = in_wait ? lat_wstrb : req_wstrb;

    assign a_err = (a_addr[1:0] != 2'b00) ||
                   ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign a_idx  = a_addr[AW+1:2];
    assign mem_we = go && a_write && !a_err && reset_n;

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_wstrb[i]) begin
                    mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM, request latch and registered response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_wstrb <= 4'd0;
        end else begin
            rsp_valid <= go;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
            end
            if (go) begin
                rsp_err   <= a_err;
                rsp_rdata <= (a_write || a_err) ? 32'd0 : mem[a_idx];
            end
            unique case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances at LATENCY 0, 1 and 3,
// checked against a byte-array memory model.
module tb_mem_bus_responder;

    localparam int DEPTH = 256;
    localparam int LAT0  = 0;
    localparam int LAT1  = 1;
    localparam int LAT2  = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int vectors = 0;
    int miscompares = 0;
    int lats [3] = '{LAT0, LAT1, LAT2};

    logic [7:0] mb [3][4*DEPTH];

    always #5 clk = ~clk;

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT2)) u2 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2])
    );

    // Reference: byte-addressed memory, errors from address arithmetic.
    function automatic void model_xact(input int k, input bit w,
                                       input logic [31:0] a,
                                       input logic [31:0] wd,
                                       input logic [3:0] st,
                                       output logic [31:0] rd,
                                       output logic er);
        er = ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
        rd = 32'd0;
        if (!er) begin
            for (int i = 0; i < 4; i++) begin
                if (w) begin
                    if (st[i]) mb[k][a + i] = wd[8*i +: 8];
                end else begin
                    rd[8*i +: 8] = mb[k][a + i];
                end
            end
        end
    endfunction

    // Issue one request from idle and collect its response.
    task automatic drive(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output logic er,
                         output int cyc, output logic rdy,
                         output logic after);
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        req_wstrb[k] = st;
        req_valid[k] = 1'b1;
        rdy = req_ready[k];
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_write[k] = ~w;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_wstrb[k] = 4'($urandom);
        cyc = 0;
        while (rsp_valid[k] !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd = rsp_rdata[k];
        er = rsp_err[k];
        @(posedge clk); #1;
        after = rsp_valid[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            req_wstrb[k] = 4'd0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rsp_valid[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_valid[%0d]: got %b want 0", k, rsp_valid[k]);
            end
            vectors++;
            if (rsp_rdata[k] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_rdata[%0d]: got %h want 0", k, rsp_rdata[k]);
            end
            vectors++;
            if (rsp_err[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_err[%0d]: got %b want 0", k, rsp_err[k]);
            end
            vectors++;
            if (req_ready[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ready[%0d]: got %b want 1", k, req_ready[k]);
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, d, a;
        logic er, eer, rdy, after;
        int cyc;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w <= 64; w++) begin
                a = (w == 64) ? 32'h3FC : 32'(w * 4);
                d = $urandom;
                model_xact(k, 1'b1, a, d, 4'hF, erd, eer);
                drive(k, 1'b1, a, d, 4'hF, rd, er, cyc, rdy, after);
                vectors++;
                if (er !== eer || cyc != lats[k]) begin
                    miscompares++;
                    $display("FAIL fill[%0d] %h: err %b lat %0d want err %b lat %0d",
                             k, a, er, cyc, eer, lats[k]);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd, w0;
        logic er, eer, rdy, after;
        int cyc;
        drive(1, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, er, cyc, rdy, after);
        model_xact(1, 1'b1, 32'h40, 32'h12345678, 4'hF, erd, eer);
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL dir_ready: got %b want 1", rdy);
        end
        vectors++;
        if (cyc != LAT1) begin
            miscompares++;
            $display("FAIL dir_latency: got %0d want %0d", cyc, LAT1);
        end
        vectors++;
        if (er !== 1'b0 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL dir_write_rsp: got err %b rdata %h want 0 0", er, rd);
        end
        vectors++;
        if (after !== 1'b0) begin
            miscompares++;
            $display("FAIL dir_pulse: got %b want 0", after);
        end
        drive(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL dir_read40: got %h err %b want 12345678 0", rd, er);
        end
        drive(1, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, cyc, rdy, after);
        model_xact(1, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, erd, eer);
        drive(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (rd !== 32'h12BB56DD) begin
            miscompares++;
            $display("FAIL dir_lanes: got %h want 12bb56dd", rd);
        end
        drive(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, rd, er, cyc, rdy, after);
        drive(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (rd !== 32'h12BB56DD || er !== 1'b0) begin
            miscompares++;
            $display("FAIL dir_strb0: got %h err %b want 12bb56dd 0", rd, er);
        end
        drive(1, 1'b0, 32'h42, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL dir_misalign: got err %b rdata %h want 1 0", er, rd);
        end
        drive(1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, rd, er, cyc, rdy, after);
        vectors++;
        if (er !== 1'b1 || rd !== 32'd0 || cyc != LAT1) begin
            miscompares++;
            $display("FAIL dir_range: got err %b rdata %h lat %0d want 1 0 %0d",
                     er, rd, cyc, LAT1);
        end
        model_xact(1, 1'b0, 32'h0, 32'h0, 4'h0, w0, eer);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (rd !== w0) begin
            miscompares++;
            $display("FAIL dir_alias0: got %h want %h", rd, w0);
        end
        model_xact(1, 1'b0, 32'h3FC, 32'h0, 4'h0, w0, eer);
        drive(1, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (rd !== w0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL dir_lastword: got %h err %b want %h 0", rd, er, w0);
        end
    endtask

    task automatic test_random(input int k, input int n);
        logic [31:0] a, d, rd, erd;
        logic [3:0] st;
        logic er, eer, rdy, after;
        bit w;
        int cyc, r, wd;
        for (int t = 0; t < n; t++) begin
            r  = $urandom_range(0, 9);
            wd = $urandom_range(0, 64);
            a  = (wd == 64) ? 32'h3FC : 32'(wd * 4);
            if (r == 8) a = a + 32'($urandom_range(1, 3));
            if (r == 9) a = $urandom | 32'h400;
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            st = 4'($urandom);
            model_xact(k, w, a, d, st, erd, eer);
            drive(k, w, a, d, st, rd, er, cyc, rdy, after);
            vectors++;
            if (rd !== erd || er !== eer) begin
                miscompares++;
                $display("FAIL rand[%0d] %s %h: got %h err %b want %h err %b",
                         k, w ? "wr" : "rd", a, rd, er, erd, eer);
            end
            vectors++;
            if (cyc != lats[k] || after !== 1'b0 || rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: lat %0d pulse_after %b ready %b want %0d 0 1",
                         k, cyc, after, rdy, lats[k]);
            end
        end
    endtask

    task automatic test_back_to_back(input int k);
        logic [31:0] addrs [4];
        logic [31:0] exp [4];
        logic eer, hs;
        int idx, pulses, edge_n, exp_edge, lat;
        lat = lats[k];
        for (int i = 0; i < 4; i++) begin
            addrs[i] = 32'($urandom_range(0, 63) * 4);
            model_xact(k, 1'b0, addrs[i], 32'h0, 4'h0, exp[i], eer);
        end
        idx = 0;
        pulses = 0;
        edge_n = 0;
        req_write[k] = 1'b0;
        req_addr[k]  = addrs[0];
        req_valid[k] = 1'b1;
        while (pulses < 4 && edge_n < 4 * (lat + 1) + 10) begin
            hs = req_valid[k] && req_ready[k];
            @(posedge clk); #1;
            edge_n++;
            if (hs) begin
                idx++;
                if (idx < 4) req_addr[k] = addrs[idx];
                else req_valid[k] = 1'b0;
            end
            if (rsp_valid[k] === 1'b1) begin
                exp_edge = 1 + lat + pulses * (lat + 1);
                vectors++;
                if (edge_n != exp_edge || rsp_rdata[k] !== exp[pulses]) begin
                    miscompares++;
                    $display("FAIL b2b[%0d] #%0d: edge %0d data %h want edge %0d data %h",
                             k, pulses, edge_n, rsp_rdata[k], exp_edge, exp[pulses]);
                end
                pulses++;
            end
        end
        req_valid[k] = 1'b0;
        vectors++;
        if (pulses != 4) begin
            miscompares++;
            $display("FAIL b2b_count[%0d]: got %0d pulses want 4", k, pulses);
        end
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_tail[%0d]: got %b want 0", k, rsp_valid[k]);
        end
    endtask

    task automatic test_reset_store();
        logic [31:0] old, rd;
        logic eer, er, rdy, after, seen;
        int cyc;
        model_xact(2, 1'b0, 32'h10, 32'h0, 4'h0, old, eer);
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h10;
        req_wdata[2] = 32'hDEADBEEF;
        req_wstrb[2] = 4'hF;
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        vectors++;
        if (rsp_rdata[2] !== 32'd0 || rsp_err[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async: rdata %h err %b ready %b want 0 0 1",
                     rsp_rdata[2], rsp_err[2], req_ready[2]);
        end
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid[2];
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid[2];
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_store_pulse: got %b want 0", seen);
        end
        drive(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc, rdy, after);
        vectors++;
        if (rd !== old || er !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_store_data: got %h err %b want %h 0", rd, er, old);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random(0, 120);
        test_random(1, 120);
        test_random(2, 120);
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_store();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
